// File: rtl/alu_pkg.sv
// alu_pkg: shared opcode and FSM state definitions for alu_pipe and its helpers.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_MUL  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_NOTA = 3'b101;
  localparam logic [2:0] OP_SUB  = 3'b110;
  localparam logic [2:0] OP_ILL  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,  // no result held
    ST_BUSY = 2'd1,  // multiply in progress
    ST_DONE = 2'd2   // result held, out_valid high
  } state_e;

endpackage

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: operand and result handshake bundle for alu_pipe.
//   master: producer/consumer side (drives operands and out_ready)
//   slave : the ALU (drives in_ready, out_valid, result and flags)
interface alu_pipe_if #(
  parameter int unsigned WIDTH = 8
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   A;
  logic [WIDTH-1:0]   B;
  logic [2:0]         OP;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               carry;
  logic               zero;
  logic               illegal;

  modport master (
    output in_valid, A, B, OP, out_ready,
    input  in_ready, out_valid, result, carry, zero, illegal
  );

  modport slave (
    input  in_valid, A, B, OP, out_ready,
    output in_ready, out_valid, result, carry, zero, illegal
  );
endinterface

// File: rtl/alu_seq_mul.sv
// alu_seq_mul: iterative shift-add unsigned multiplier, one partial product per cycle.
// Ports:
//   CLK, rst_n : clock, synchronous active-low reset
//   start      : load a/b and begin (ignored semantics while busy are the caller's concern)
//   a, b       : multiplicand / multiplier
//   busy       : high for exactly WIDTH cycles after start
//   done       : pulses in the last busy cycle; product is valid in that cycle
//   product    : full 2*WIDTH product
module alu_seq_mul #(
  parameter int unsigned WIDTH = 8
) (
  input  logic               CLK,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] CntInit = CntW'(WIDTH);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  logic                busy_q, busy_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]    mplier_q, mplier_d;
  logic [2*WIDTH-1:0]  acc_q, acc_d;

  always_comb begin
    busy_d   = busy_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start) begin
      busy_d   = 1'b1;
      cnt_d    = CntInit;
      mcand_d  = {{WIDTH{1'b0}}, a};
      mplier_d = b;
      acc_d    = '0;
    end else if (busy_q) begin
      if (mplier_q[0]) acc_d = acc_q + mcand_q;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q - CntLast;
      if (cnt_q == CntLast) busy_d = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      busy_q   <= 1'b0;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      busy_q   <= busy_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  assign busy    = busy_q;
  assign done    = busy_q && (cnt_q == CntLast);
  // Next-state accumulator so the caller can register the product on the final iteration edge.
  assign product = acc_d;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: unsigned ALU with valid/ready handshakes on operand and result sides.
// Single-cycle ops complete in 1 cycle; MUL uses alu_seq_mul and takes WIDTH busy cycles.
// Ports:
//   CLK, rst_n : clock, synchronous active-low reset
//   bus        : alu_pipe_if slave (operands/opcode in, result/carry/zero/illegal out)
module alu_pipe
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic       CLK,
  input  logic       rst_n,
  alu_pipe_if.slave  bus
);
  state_e             state_q, state_d;
  logic [2*WIDTH-1:0] result_q, result_d;
  logic               carry_q, carry_d;
  logic               zero_q, zero_d;
  logic               illegal_q, illegal_d;

  logic               accept;
  logic               mul_start, mul_busy, mul_done;
  logic [2*WIDTH-1:0] mul_product;
  logic [2*WIDTH-1:0] a_ext, b_ext, sum;
  logic [WIDTH:0]     diff;

  assign bus.in_ready = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign mul_start    = accept && (bus.OP == OP_MUL);

  assign a_ext = {{WIDTH{1'b0}}, bus.A};
  assign b_ext = {{WIDTH{1'b0}}, bus.B};
  assign sum   = a_ext + b_ext;
  // Extra top bit of the difference is the borrow (A < B).
  assign diff  = {1'b0, bus.A} - {1'b0, bus.B};

  alu_seq_mul #(
    .WIDTH (WIDTH)
  ) u_mul (
    .CLK     (CLK),
    .rst_n   (rst_n),
    .start   (mul_start),
    .a       (bus.A),
    .b       (bus.B),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    illegal_d = illegal_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (bus.OP == OP_MUL) begin
            state_d = ST_BUSY;
          end else begin
            state_d   = ST_DONE;
            carry_d   = 1'b0;
            illegal_d = 1'b0;
            result_d  = '0;
            unique case (bus.OP)
              OP_ADD: begin
                result_d = sum;
                carry_d  = sum[WIDTH];
              end
              OP_SUB: begin
                result_d[WIDTH-1:0] = diff[WIDTH-1:0];
                carry_d             = diff[WIDTH];
              end
              OP_AND:  result_d[WIDTH-1:0] = bus.A & bus.B;
              OP_OR:   result_d[WIDTH-1:0] = bus.A | bus.B;
              OP_XOR:  result_d[WIDTH-1:0] = bus.A ^ bus.B;
              OP_NOTA: result_d[WIDTH-1:0] = ~bus.A;
              default: illegal_d = 1'b1;
            endcase
            zero_d = (result_d == '0);
          end
        end else if (state_q == ST_DONE && bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        if (mul_done) begin
          state_d   = ST_DONE;
          result_d  = mul_product;
          carry_d   = 1'b0;
          illegal_d = 1'b0;
          zero_d    = (mul_product == '0);
        end else if (!mul_busy) begin
          // Multiplier lost its operation; never present a stale product.
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      result_q  <= result_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.out_valid = (state_q == ST_DONE);
  assign bus.result    = result_q;
  assign bus.carry     = carry_q;
  assign bus.zero      = zero_q;
  assign bus.illegal   = illegal_q;

endmodule

// File: tb/tb_alu_pipe.sv
module tb_alu_pipe;
  import alu_pkg::*;

  localparam int unsigned W = 8;

  typedef struct packed {
    logic [2*W-1:0] res;
    logic           c;
    logic           z;
    logic           i;
  } exp_t;

  logic CLK = 1'b0;
  logic rst_n;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(
    .WIDTH (W)
  ) dut (
    .CLK   (CLK),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: every completed result handshake is checked against the scoreboard.
  always @(negedge CLK) begin
    if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      exp_t e;
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_output: got res=0x%0h with no result pending", bus.result);
      end else begin
        e = sb.pop_front();
        if ({bus.result, bus.carry, bus.zero, bus.illegal} !== e) begin
          miscompares++;
          $display("FAIL result: got res=0x%0h c=%0b z=%0b i=%0b, expected res=0x%0h c=%0b z=%0b i=%0b",
                   bus.result, bus.carry, bus.zero, bus.illegal, e.res, e.c, e.z, e.i);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [2*W-1:0] res, input logic c, input logic i,
                      input bit push, output int waits);
    bus.in_valid = 1'b1;
    bus.OP = op;
    bus.A  = a;
    bus.B  = b;
    waits  = 0;
    forever begin
      @(negedge CLK);
      if (bus.in_ready === 1'b1) break;
      waits++;
      if (waits > 40) begin
        $display("FAIL accept_timeout: in_ready stuck at %0b, expected 1", bus.in_ready);
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "timeout");
      end
    end
    if (push) sb.push_back({res, c, (res == '0), i});
    @(posedge CLK);
    #1;
    bus.in_valid = 1'b0;
    bus.A  = '1;
    bus.B  = '1;
    bus.OP = OP_AND;
  endtask

  // Counts negedges to out_valid; flags in_ready high while waiting.
  task automatic wait_valid(output int cycles, output int ready_seen);
    cycles = 0;
    ready_seen = 0;
    while (cycles < 40) begin
      @(negedge CLK);
      cycles++;
      if (bus.out_valid === 1'b1) break;
      if (bus.in_ready !== 1'b0) ready_seen++;
    end
  endtask

  initial begin
    int w, cyc, rdy;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    bus.A = '0;
    bus.B = '0;
    bus.OP = OP_ADD;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_flags", {bus.result, 13'd0, bus.carry, bus.zero, bus.illegal}, 32'd0);
    @(posedge CLK);
    #1 rst_n = 1'b1;

    // ADD with carry, 1-cycle latency
    send(OP_ADD, 8'd200, 8'd100, 16'h012C, 1'b1, 1'b0, 1'b1, w);
    @(negedge CLK);
    check("add_latency", 32'(bus.out_valid), 32'd1);
    @(posedge CLK); #1;

    // MUL 255*255: 8 busy cycles, valid on 9th
    send(OP_MUL, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 1'b0, 1'b1, w);
    wait_valid(cyc, rdy);
    check("mul_latency", 32'(cyc), 32'd9);
    check("mul_busy_in_ready", 32'(rdy), 32'd0);
    @(posedge CLK); #1;

    // MUL by zero still takes WIDTH cycles
    send(OP_MUL, 8'h00, 8'hAB, 16'h0000, 1'b0, 1'b0, 1'b1, w);
    wait_valid(cyc, rdy);
    check("mul0_latency", 32'(cyc), 32'd9);
    @(posedge CLK); #1;
    send(OP_MUL, 8'd13, 8'd11, 16'h008F, 1'b0, 1'b0, 1'b1, w);
    wait_valid(cyc, rdy);
    @(posedge CLK); #1;

    // SUB borrow and zero, back-to-back
    send(OP_SUB, 8'd5, 8'd7, 16'h00FE, 1'b1, 1'b0, 1'b1, w);
    send(OP_SUB, 8'd7, 8'd7, 16'h0000, 1'b0, 1'b0, 1'b1, w);
    check("b2b_accept", 32'(w), 32'd0);
    send(OP_OR, 8'hA5, 8'h0F, 16'h00AF, 1'b0, 1'b0, 1'b1, w);
    send(OP_ADD, 8'hFF, 8'hFF, 16'h01FE, 1'b1, 1'b0, 1'b1, w);
    @(posedge CLK); #1;

    // Backpressure
    bus.out_ready = 1'b0;
    send(OP_AND, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1'b0, 1'b1, w);
    for (int k = 0; k < 5; k++) begin
      @(negedge CLK);
      check("bp_hold", {bus.result, 13'd0, bus.out_valid, bus.in_ready, bus.carry},
            {16'h0030, 13'd0, 1'b1, 1'b0, 1'b0});
    end
    @(posedge CLK); #1;
    bus.out_ready = 1'b1;
    send(OP_XOR, 8'hFF, 8'h0F, 16'h00F0, 1'b0, 1'b0, 1'b1, w);
    check("bp_release_accept", 32'(w), 32'd0);

    // Illegal opcode then NOTA
    send(OP_ILL, 8'd1, 8'd1, 16'h0000, 1'b0, 1'b1, 1'b1, w);
    send(OP_NOTA, 8'h0F, 8'h00, 16'h00F0, 1'b0, 1'b0, 1'b1, w);
    @(posedge CLK); #1;
    @(posedge CLK); #1;

    // Reset in BUSY cycle 4 aborts the multiply
    send(OP_MUL, 8'h12, 8'h34, 16'h0000, 1'b0, 1'b0, 1'b0, w);
    repeat (3) @(negedge CLK);
    @(posedge CLK); #1;
    rst_n = 1'b0;
    @(posedge CLK); #1;
    rst_n = 1'b1;
    @(negedge CLK);
    check("abort_state", {bus.result, 14'd0, bus.out_valid, bus.in_ready},
          {16'h0000, 14'd0, 1'b0, 1'b1});
    repeat (15) @(posedge CLK);
    #1;
    send(OP_ADD, 8'd1, 8'd2, 16'h0003, 1'b0, 1'b0, 1'b1, w);
    repeat (4) @(posedge CLK);
    @(negedge CLK);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised unsigned ALU with valid/ready handshakes on both the operand and result sides. It replaces the fixed 8-bit, always-enabled ALU for datapaths that need backpressure and wider operands. Single-cycle ops complete in 1 cycle. MUL runs on an iterative shift-add engine taking WIDTH cycles. Results carry carry/borrow, zero and illegal-op flags.

Parameters:
WIDTH, 8, operand width in bits (≥2); result width is 2*WIDTH.

Ports:
CLK  input  1  clock, rising edge
rst_n  input  1  reset, synchronous, active-low
in_valid  input  1  operand/op presented
in_ready  output  1  block can accept operands this cycle
A  input  WIDTH  operand A, unsigned
B  input  WIDTH  operand B, unsigned
OP  input  3  opcode
out_valid  output  1  result and flags valid
out_ready  input  1  consumer accepts result
result  output  2*WIDTH  result, zero-extended where narrower
carry  output  1  ADD carry-out / SUB borrow; 0 for other ops
zero  output  1  result == 0
illegal  output  1  OP was 3'b111

Behaviour:
- Reset is synchronous on rst_n low: state IDLE, out_valid=0, result=0, carry=0, zero=0, illegal=0, multiplier counter and accumulator cleared.
- Reset mid-multiply aborts the operation; no result is produced.
- Opcodes: 000 ADD, 001 MUL, 010 AND, 011 OR, 100 XOR, 101 NOTA, 110 SUB, 111 illegal.
- States:
  - IDLE (no result held).
  - BUSY (multiply in progress).
  - DONE (result held, out_valid=1).
- in_ready = (state==IDLE) || (state==DONE && out_ready). in_ready is 0 in BUSY.
- Accept = in_valid && in_ready. A, B and OP are captured on accept; later input changes are ignored.
- On accept of a non-MUL op:
  - Result and flags are registered; state goes to DONE next cycle.
  - Latency is 1 cycle (out_valid high the cycle after accept).
- On accept of MUL:
  - State goes to BUSY for exactly WIDTH cycles. Each cycle: if multiplier LSB is 1, add multiplicand into the accumulator; shift.
  - Then DONE. Latency is WIDTH+1 cycles from accept to out_valid.
- In DONE, result and flags hold stable while out_ready=0.
- On out_ready=1 in DONE:
  - With a simultaneous accept, the new op proceeds: next state DONE (non-MUL) or BUSY (MUL).
  - Otherwise the state goes to IDLE and out_valid falls.
- Single-cycle ops therefore sustain 1 result per cycle under continuous in_valid/out_ready.
- Width rules (upper bits are 0 unless stated):
  - ADD: result = A+B in the low WIDTH+1 bits; carry = bit WIDTH.
  - SUB: result[WIDTH-1:0] = (A-B) mod 2^WIDTH; carry = 1 iff A<B.
  - MUL: full 2*WIDTH product; carry=0.
  - AND/OR/XOR: low WIDTH bits; carry=0.
  - NOTA: ~A in the low WIDTH bits; carry=0.
  - Illegal: result=0, carry=0, illegal=1; completes with 1-cycle latency like other ops.
- zero is computed from the final registered result. It is valid in DONE only; otherwise it holds the last value or the reset value.
- Boundary cases:
  - MUL by 0 still takes WIDTH cycles.
  - MUL 0xFF*0xFF at WIDTH=8 gives 0xFE01.
  - in_valid in BUSY is not accepted; the upstream holds it.

Decomposition:
- Package alu_pkg:
  - Opcode localparams: OP_ADD, OP_MUL, OP_AND, OP_OR, OP_XOR, OP_NOTA, OP_SUB, OP_ILL.
  - State encoding: ST_IDLE, ST_BUSY, ST_DONE.
- Sub-module alu_seq_mul (WIDTH):
  - Inputs: start, a, b.
  - Outputs: busy, done pulse, product[2*WIDTH].
  - Owns the counter ($clog2(WIDTH+1) bits), accumulator and shift registers.
- Top-level alu_pipe holds the handshake FSM, single-cycle datapath and output registers.

Test Plan:
1. WIDTH=8, ADD A=200 B=100, out_ready=1 -> 1 cycle after accept: result=0x012C, carry=1, zero=0, illegal=0.
2. MUL A=255 B=255 -> in_ready=0 for 8 cycles, out_valid on cycle 9 after accept, result=0xFE01, carry=0.
3. SUB A=5 B=7 -> result=0x00FE, carry=1. Then SUB A=7 B=7 -> result=0x0000, zero=1, carry=0.
4. Backpressure: AND A=0xF0 B=0x3C with out_ready=0 for 5 cycles -> result=0x0030 stable, out_valid=1, in_ready=0 throughout. Raising out_ready with in_valid (XOR 0xFF,0x0F) -> accepted that cycle, next result=0x00F0.
5. OP=111 A=1 B=1 -> result=0, illegal=1, zero=1. Then NOTA A=0x0F -> result=0x00F0, illegal=0.
6. rst_n low 1 cycle at BUSY cycle 4 of a MUL -> next cycle out_valid=0, in_ready=1, result=0. No stale product ever appears.
